// File: rtl/mss_uart_rx_pkg.sv
// Shared types and bit-timing constants for the MSS UART receive path.
package mss_uart_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;

  localparam int         OVERSAMPLE  = 16;
  localparam logic [3:0] OS_LAST     = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] SAMPLE_A    = 4'd7;
  localparam logic [3:0] SAMPLE_B    = 4'd8;
  localparam logic [3:0] SAMPLE_C    = 4'd9;
  localparam logic [3:0] STOP_DECIDE = 4'd9;
  localparam int         DATA_BITS   = 8;

  // 2-of-3 vote over the mid-bit samples
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/mss_uart_rx_irq_if.sv
// Serial input plus FWFT receive handshake, error pulses and interrupt.
interface mss_uart_rx_irq_if;
  logic       MMUART_0_TXD;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_READY;
  logic       FRAMING_ERR;
  logic       OVERRUN;
  logic       IRQ_OUT;

  modport master (input MMUART_0_TXD, RX_READY,
                  output RX_DATA, RX_VALID, FRAMING_ERR, OVERRUN, IRQ_OUT);
  modport slave  (output MMUART_0_TXD, RX_READY,
                  input RX_DATA, RX_VALID, FRAMING_ERR, OVERRUN, IRQ_OUT);
endinterface

// File: rtl/mss_uart_rx_fifo.sv
// Small first-word-fall-through FIFO; exposes next-cycle count for the IRQ flop.
module mss_uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     count_nxt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign count_nxt = count + CW'(do_push) - CW'(do_pop);
  assign rdata   = mem[rd_ptr];

  // storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end
endmodule

// File: rtl/mss_uart_rx_irq.sv
// 8N1 receiver with 16x oversampling, receive FIFO and level interrupt.
module mss_uart_rx_irq
  import mss_uart_rx_pkg::*;
#(
  parameter int BAUD_DIV   = 27,
  parameter int FIFO_DEPTH = 4,
  parameter int IRQ_LEVEL  = 1
) (
  input logic                FAB_CCC_GL0,
  input logic                FAB_RESET,
  mss_uart_rx_irq_if.master  bus
);
  localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rx_state_e     state, state_nxt;
  logic          sync1, rxd;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    os_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          s_a, s_b, s_c, maj;
  logic          start_go, dec15, stop_dec;
  logic          push, fe_set, empty;
  logic [7:0]    rdata;
  logic [CW-1:0] count, count_nxt;
  logic          fe_q, ov_q, irq_q;

  assign tick     = (tick_cnt == TW'(BAUD_DIV - 1));
  assign start_go = (state == IDLE) && !rxd;
  assign dec15    = tick && (os_cnt == OS_LAST);
  assign stop_dec = (state == STOP) && tick && (os_cnt == STOP_DECIDE);
  // the stop decision lands on the third sample itself, so vote with the live bit
  assign maj      = maj3(s_a, s_b, (os_cnt == SAMPLE_C) ? rxd : s_c);

  // line synchronizer, baud/oversample counters, mid-bit samples, shift register
  always_ff @(posedge FAB_CCC_GL0 or posedge FAB_RESET) begin
    if (FAB_RESET) begin
      sync1    <= 1'b1;
      rxd      <= 1'b1;
      tick_cnt <= '0;
      os_cnt   <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      s_a      <= 1'b1;
      s_b      <= 1'b1;
      s_c      <= 1'b1;
    end else begin
      sync1 <= bus.MMUART_0_TXD;
      rxd   <= sync1;
      if (start_go) begin
        tick_cnt <= '0;
        os_cnt   <= '0;
        bit_idx  <= '0;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
        if (tick) os_cnt <= os_cnt + 4'd1;
        if (state == DATA && dec15) bit_idx <= bit_idx + 3'd1;
      end
      if (tick) begin
        if (os_cnt == SAMPLE_A) s_a <= rxd;
        if (os_cnt == SAMPLE_B) s_b <= rxd;
        if (os_cnt == SAMPLE_C) s_c <= rxd;
      end
      if (state == DATA && dec15) shreg <= {maj, shreg[7:1]};
    end
  end

  // state register
  always_ff @(posedge FAB_CCC_GL0 or posedge FAB_RESET) begin
    if (FAB_RESET) state <= IDLE;
    else           state <= state_nxt;
  end

  // frame sequencing; push or framing error is raised in the stop-decision cycle
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    fe_set    = 1'b0;
    case (state)
      IDLE:  if (!rxd) state_nxt = START;
      START: if (dec15) state_nxt = maj ? IDLE : DATA;
      DATA:  if (dec15 && bit_idx == 3'(DATA_BITS - 1)) state_nxt = STOP;
      STOP:  if (stop_dec) begin
               if (maj) begin
                 push      = 1'b1;
                 state_nxt = IDLE;
               end else begin
                 fe_set    = 1'b1;
                 state_nxt = BREAK;
               end
             end
      BREAK: if (rxd) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  mss_uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk       (FAB_CCC_GL0),
    .rst       (FAB_RESET),
    .push      (push),
    .pop       (bus.RX_READY),
    .wdata     (shreg),
    .rdata     (rdata),
    .empty     (empty),
    .count     (count),
    .count_nxt (count_nxt)
  );

  // registered pulses and interrupt level
  always_ff @(posedge FAB_CCC_GL0 or posedge FAB_RESET) begin
    if (FAB_RESET) begin
      fe_q  <= 1'b0;
      ov_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      fe_q  <= fe_set;
      ov_q  <= push && (count == CW'(FIFO_DEPTH)) && !bus.RX_READY;
      irq_q <= (count_nxt >= CW'(IRQ_LEVEL));
    end
  end

  assign bus.RX_VALID    = !empty;
  assign bus.RX_DATA     = rdata;
  assign bus.FRAMING_ERR = fe_q;
  assign bus.OVERRUN     = ov_q;
  assign bus.IRQ_OUT     = irq_q;
endmodule

// File: tb/tb_mss_uart_rx_irq.sv
// Directed bench: frame-level model of the receive FIFO, checked every cycle.
module tb_mss_uart_rx_irq;
  localparam int DEPTH = 4;
  localparam int LVL   = 1;
  // TXD falling edge to FIFO push edge: 2 sync + 1 detect + 16 start + 128 data + 10 stop
  localparam int LAT   = 157;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0;
  int   fe_cnt = 0, ov_cnt = 0;

  byte unsigned q_m[$];
  int           due_q[$];
  byte unsigned dat_q[$];
  bit           ok_q[$];
  bit           exp_fe = 1'b0, exp_ov = 1'b0;

  mss_uart_rx_irq_if bus();

  mss_uart_rx_irq #(.BAUD_DIV(1), .FIFO_DEPTH(DEPTH), .IRQ_LEVEL(LVL)) dut (
    .FAB_CCC_GL0 (clk),
    .FAB_RESET   (rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // model flush on reset
  always @(posedge rst) begin
    q_m.delete(); due_q.delete(); dat_q.delete(); ok_q.delete();
    exp_fe = 1'b0; exp_ov = 1'b0;
  end

  // model: pop first, then apply any frame that completes on this edge
  always @(posedge clk) begin
    byte unsigned b;
    bit ok;
    int d;
    cyc++;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    if (rst) begin
      q_m.delete(); due_q.delete(); dat_q.delete(); ok_q.delete();
    end else begin
      if (bus.RX_READY && q_m.size() > 0) void'(q_m.pop_front());
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        d  = due_q.pop_front();
        b  = dat_q.pop_front();
        ok = ok_q.pop_front();
        if (!ok)                    exp_fe = 1'b1;
        else if (q_m.size() >= DEPTH) exp_ov = 1'b1;
        else                        q_m.push_back(b);
      end
    end
  end

  // per-cycle comparison
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid", 32'(bus.RX_VALID), 0);
      chk("rst_data",  32'(bus.RX_DATA), 0);
      chk("rst_irq",   32'(bus.IRQ_OUT), 0);
      chk("rst_fe",    32'(bus.FRAMING_ERR), 0);
      chk("rst_ov",    32'(bus.OVERRUN), 0);
    end else begin
      chk("valid", 32'(bus.RX_VALID), 32'(q_m.size() > 0));
      if (q_m.size() > 0) chk("data", 32'(bus.RX_DATA), 32'(q_m[0]));
      chk("irq", 32'(bus.IRQ_OUT), 32'(q_m.size() >= LVL));
      chk("framing_err", 32'(bus.FRAMING_ERR), 32'(exp_fe));
      chk("overrun", 32'(bus.OVERRUN), 32'(exp_ov));
    end
    fe_cnt += int'(bus.FRAMING_ERR);
    ov_cnt += int'(bus.OVERRUN);
  end

  task automatic send(input logic [7:0] b, input logic stp);
    logic [9:0] f;
    f = {stp, b, 1'b0};
    @(posedge clk); #1;
    due_q.push_back(cyc + LAT); dat_q.push_back(b); ok_q.push_back(stp);
    for (int j = 0; j < 10; j++) begin
      bus.MMUART_0_TXD = f[j];
      repeat (16) @(posedge clk);
      #1;
    end
  endtask

  task automatic pop_expect(input logic [7:0] v);
    chk("pop_valid", 32'(bus.RX_VALID), 1);
    chk("pop_data", 32'(bus.RX_DATA), 32'(v));
    bus.RX_READY = 1'b1;
    @(posedge clk); #1;
    bus.RX_READY = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int fe0, ov0;
    logic [7:0] pb;
    bus.MMUART_0_TXD = 1'b1;
    bus.RX_READY     = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_irq_lit", 32'(bus.IRQ_OUT), 0);
    chk("reset_valid_lit", 32'(bus.RX_VALID), 0);
    rst = 1'b0;
    repeat (5) @(posedge clk); #1;

    // 1: single frame, then pop
    send(8'hA5, 1'b1);
    chk("t1_valid", 32'(bus.RX_VALID), 1);
    chk("t1_data", 32'(bus.RX_DATA), 32'hA5);
    chk("t1_irq", 32'(bus.IRQ_OUT), 1);
    bus.RX_READY = 1'b1;
    @(posedge clk); #1;
    bus.RX_READY = 1'b0;
    chk("t1_valid_after_pop", 32'(bus.RX_VALID), 0);
    chk("t1_irq_after_pop", 32'(bus.IRQ_OUT), 0);

    // 2: short glitch rejected as a false start
    fe0 = fe_cnt; ov0 = ov_cnt;
    bus.MMUART_0_TXD = 1'b0;
    repeat (4) @(posedge clk); #1;
    bus.MMUART_0_TXD = 1'b1;
    repeat (40) @(posedge clk); #1;
    chk("t2_valid", 32'(bus.RX_VALID), 0);
    chk("t2_pulses", 32'(fe_cnt - fe0 + ov_cnt - ov0), 0);

    // 3: bad stop bit, line held low, then a good frame
    fe0 = fe_cnt;
    send(8'h3C, 1'b0);
    repeat (40) @(posedge clk); #1;
    bus.MMUART_0_TXD = 1'b1;
    repeat (30) @(posedge clk); #1;
    chk("t3_fe_count", 32'(fe_cnt - fe0), 1);
    chk("t3_valid", 32'(bus.RX_VALID), 0);
    send(8'h55, 1'b1);
    pop_expect(8'h55);

    // 4: five frames into a four-entry FIFO
    ov0 = ov_cnt;
    for (int k = 1; k <= 5; k++) send(8'(k), 1'b1);
    chk("t4_ov_count", 32'(ov_cnt - ov0), 1);
    for (int k = 1; k <= 4; k++) begin
      pb = 8'(k);
      pop_expect(pb);
    end
    chk("t4_empty", 32'(bus.RX_VALID), 0);

    // 5: full FIFO, pop in the same cycle as a push
    ov0 = ov_cnt;
    send(8'h11, 1'b1); send(8'h22, 1'b1); send(8'h33, 1'b1); send(8'h44, 1'b1);
    fork
      send(8'h99, 1'b1);
      begin
        @(posedge clk); #1;
        repeat (LAT - 1) @(posedge clk);
        #1 bus.RX_READY = 1'b1;
        @(posedge clk); #1;
        bus.RX_READY = 1'b0;
      end
    join
    chk("t5_no_overrun", 32'(ov_cnt - ov0), 0);
    pop_expect(8'h22); pop_expect(8'h33); pop_expect(8'h44); pop_expect(8'h99);
    chk("t5_empty", 32'(bus.RX_VALID), 0);

    // 6: reset during data bit 3 with one byte already buffered
    send(8'h42, 1'b1);
    bus.MMUART_0_TXD = 1'b0;
    repeat (16) @(posedge clk); #1;
    pb = 8'h5A;
    for (int j = 0; j < 3; j++) begin
      bus.MMUART_0_TXD = pb[j];
      repeat (16) @(posedge clk); #1;
    end
    bus.MMUART_0_TXD = pb[3];
    repeat (8) @(posedge clk); #1;
    rst = 1'b1;
    bus.MMUART_0_TXD = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("t6_valid_in_rst", 32'(bus.RX_VALID), 0);
    chk("t6_data_in_rst", 32'(bus.RX_DATA), 0);
    rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("t6_valid_after_rst", 32'(bus.RX_VALID), 0);
    send(8'h7E, 1'b1);
    pop_expect(8'h7E);
    chk("t6_empty", 32'(bus.RX_VALID), 0);

    repeat (5) @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
